transpose_nxn: RTL and testbench
================================

// Module: transpose_nxn
// PURPOSE
//  Parametrised block transpose buffer for the JPEG encoder DCT path (between the 1-D row and column passes).
//  Accepts an NxN block one row per beat and emits it one column per beat.
//  Holds NBUF blocks in flop storage so writes and reads overlap at full rate.
//  Each block can be flagged passthrough: rows are emitted unchanged.
//  Reports row-sequence errors.
// PARAMETERS
//  N     8   block dimension (rows = cols = lanes); N>=2, power of 2
//  QW    12  signed element width (12 first pass, 15 second pass)
//  NBUF  2   blocks of storage; NBUF>=1
// PORTS
//  clk      in   1          single clock, all logic rising edge
//  reset    in   1          asynchronous, active-high; clears all state
//  d        in   N x QW     signed input row, lane i = element i of the row
//  d_cnt    in   log2(N)    row index of d within the block
//  d_mode   in   1          0=transpose, 1=passthrough; sampled on row 0 only
//  d_valid  in   1          input beat valid
//  d_hold   out  1          back-pressure to producer
//  q        out  N x QW     signed output column (or row in passthrough)
//  q_cnt    out  log2(N)    column (row) index of q
//  q_mode   out  1          mode of the block being emitted
//  q_last   out  1          q is the final beat of its block
//  q_valid  out  1          output beat valid
//  q_hold   in   1          back-pressure from consumer
//  err_seq  out  1          sticky: d_cnt mismatched expected row index
// BEHAVIOUR
//  - Handshake (both sides): beat transfers when valid & ~hold. q, q_cnt, q_mode, q_last, q_valid are registered and held stable while q_valid & q_hold.
//  - Reset values: d_hold=0, q=0, q_cnt=0, q_mode=0, q_last=0, q_valid=0, err_seq=0. wptr, rptr, wrow, rcol, occ cleared. Reset mid-block discards all partial and stored blocks.
//  - d_hold = (occ==NBUF). Registered occupancy only; no same-cycle bypass of a freeing read.
//  - Write:
//    * accepted row goes to buf[wptr] row wrow; wrow increments and wraps N-1 -> 0.
//    * d_mode latched into mode[wptr] when wrow==0.
//    * d_cnt!=wrow on an accepted beat sets err_seq. Row is still written at wrow; d_cnt never addresses storage.
//    * when row N-1 is accepted: wptr++ (mod NBUF), occ++.
//  - Read:
//    * advance = ~q_valid | ~q_hold.
//    * if advance & occ>0: load q = col rcol of buf[rptr] (mode=1: row rcol); q_cnt=rcol; q_mode=mode[rptr]; q_last=(rcol==N-1); q_valid=1; rcol++.
//    * rcol==N-1 load: rptr++ (mod NBUF), occ--.
//    * if advance & occ==0: q_valid=0; q data holds its last value.
//  - occ update when write-complete and read-free occur in the same cycle: occ unchanged.
//  - Latency: last row sampled at edge k -> column 0 valid after edge k+1.
//  - Throughput: NBUF>=2 sustains 1 beat/cycle each side; NBUF=1 alternates fill and drain.
//  - Widths: occ is log2(NBUF+1) bits; pointers are max(1,log2(NBUF)) bits. No arithmetic on data; elements copied bit-exact, sign preserved.
//  - Storage is indexed only by wptr/rptr, never by occupancy.
// STRUCTURE
//  - jenc_pkg: typedef elem_t (logic signed [QW-1:0]); function clog2_min1().
//  - Sub-module transpose_bank: one NxN register block.
//    * row write port with we;
//    * combinational read port returning row or column by a mode select.
//    * transpose_nxn instantiates NBUF banks plus the pointer/occupancy FSM and output register.
// TESTING
//  1. N=8, NBUF=2, element (r,c)=16r+c, q_hold=0 -> q_cnt 0..7, q[i]=16i+q_cnt, q_last on beat 7, column 0 at edge k+1.
//  2. Three back-to-back blocks, no hold -> d_hold never asserts, q_valid continuous after first block, 24 beats out.
//  3. q_hold=1 throughout, 3 blocks offered -> d_hold=1 after 16 rows accepted. Release: outputs match order; q stable while held.
//  4. Passthrough block (d_mode=1 on row 0) between two transpose blocks -> middle block q[i]=16*q_cnt+i, q_mode=1.
//  5. d_cnt=3 on second row -> err_seq=1 and stays 1. Data still in wrow order. Async reset -> err_seq=0, q_valid=0.
//  6. Reset asserted after 5 rows -> after release, a new full block emits correctly with no stale rows.

Source files
------------

// File: rtl/jenc_pkg.sv
// Shared types and helpers for the JPEG encoder datapath blocks.
package jenc_pkg;

    localparam int QW_DEF = 12;

    // Default element type of the first DCT pass; QW-parametrised modules size their own lanes.
    typedef logic signed [QW_DEF-1:0] elem_t;

    function automatic int clog2_min1(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/transpose_bank.sv
// One NxN register block: row-wide write port, combinational row or column read port.
module transpose_bank #(
    parameter int N  = 8,
    parameter int QW = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [$clog2(N)-1:0]  wrow,
    input  logic [N-1:0][QW-1:0]  wdata,
    input  logic                  rsel,
    input  logic [$clog2(N)-1:0]  ridx,
    output logic [N-1:0][QW-1:0]  rdata
);

    localparam int CW = $clog2(N);

    // mem_reg[row][col]
    logic [N-1:0][N-1:0][QW-1:0] mem_reg;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_row
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    mem_reg[gi] <= '0;
                end else if (we && (wrow == CW'(gi))) begin
                    mem_reg[gi] <= wdata;
                end
            end
        end

        // rsel=1 returns row ridx unchanged, rsel=0 returns column ridx.
        for (genvar gi = 0; gi < N; gi++) begin : g_lane
            assign rdata[gi] = rsel ? mem_reg[ridx][gi] : mem_reg[gi][ridx];
        end
    endgenerate

endmodule

// File: rtl/transpose_nxn.sv
// Block transpose buffer: NxN block in one row per beat, out one column per beat,
// NBUF blocks of storage so filling and draining overlap.
module transpose_nxn
    import jenc_pkg::*;
#(
    parameter int N    = 8,
    parameter int QW   = 12,
    parameter int NBUF = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N-1:0][QW-1:0]  d,
    input  logic [$clog2(N)-1:0]  d_cnt,
    input  logic                  d_mode,
    input  logic                  d_valid,
    output logic                  d_hold,
    output logic [N-1:0][QW-1:0]  q,
    output logic [$clog2(N)-1:0]  q_cnt,
    output logic                  q_mode,
    output logic                  q_last,
    output logic                  q_valid,
    input  logic                  q_hold,
    output logic                  err_seq
);

    localparam int CW = $clog2(N);
    localparam int PW = clog2_min1(NBUF);
    localparam int OW = $clog2(NBUF + 1);

    localparam logic [CW-1:0] ROW_LAST = CW'(N - 1);
    localparam logic [CW-1:0] ROW_ONE  = CW'(1);
    localparam logic [PW-1:0] BUF_LAST = PW'(NBUF - 1);
    localparam logic [PW-1:0] BUF_ONE  = PW'(1);
    localparam logic [OW-1:0] OCC_FULL = OW'(NBUF);
    localparam logic [OW-1:0] OCC_ONE  = OW'(1);

    logic [PW-1:0]          wptr_reg, wptr_next;
    logic [PW-1:0]          rptr_reg, rptr_next;
    logic [CW-1:0]          wrow_reg, wrow_next;
    logic [CW-1:0]          rcol_reg, rcol_next;
    logic [OW-1:0]          occ_reg, occ_next;
    logic [NBUF-1:0]        mode_reg, mode_next;
    logic                   err_reg, err_next;
    logic [N-1:0][QW-1:0]   q_reg, q_next;
    logic [CW-1:0]          q_cnt_reg, q_cnt_next;
    logic                   q_mode_reg, q_mode_next;
    logic                   q_last_reg, q_last_next;
    logic                   q_valid_reg, q_valid_next;

    logic                   wr_fire, wr_done;
    logic                   advance, rd_fire, rd_done;
    logic [N-1:0][QW-1:0]   bank_rdata [NBUF];
    logic [N-1:0][QW-1:0]   rd_row;
    logic                   rd_mode;

    // Full is judged on registered occupancy only; a read freeing a slot this cycle does not unblock the writer.
    assign d_hold  = (occ_reg == OCC_FULL);
    assign wr_fire = d_valid & ~d_hold;
    assign wr_done = wr_fire & (wrow_reg == ROW_LAST);
    assign advance = ~q_valid_reg | ~q_hold;
    assign rd_fire = advance & (occ_reg != '0);
    assign rd_done = rd_fire & (rcol_reg == ROW_LAST);

    generate
        for (genvar gi = 0; gi < NBUF; gi++) begin : g_bank
            transpose_bank #(
                .N  (N),
                .QW (QW)
            ) u_bank (
                .clk   (clk),
                .reset (reset),
                .we    (wr_fire && (wptr_reg == PW'(gi))),
                .wrow  (wrow_reg),
                .wdata (d),
                .rsel  (mode_reg[gi]),
                .ridx  (rcol_reg),
                .rdata (bank_rdata[gi])
            );
        end
    endgenerate

    always_comb begin
        rd_row  = '0;
        rd_mode = 1'b0;
        for (int b = 0; b < NBUF; b++) begin
            if (rptr_reg == PW'(b)) begin
                rd_row  = bank_rdata[b];
                rd_mode = mode_reg[b];
            end
        end
    end

    always_comb begin
        wptr_next    = wptr_reg;
        rptr_next    = rptr_reg;
        wrow_next    = wrow_reg;
        rcol_next    = rcol_reg;
        occ_next     = occ_reg;
        mode_next    = mode_reg;
        err_next     = err_reg;
        q_next       = q_reg;
        q_cnt_next   = q_cnt_reg;
        q_mode_next  = q_mode_reg;
        q_last_next  = q_last_reg;
        q_valid_next = q_valid_reg;

        // d_cnt is only a sequence check; storage is always addressed by wrow.
        if (wr_fire) begin
            wrow_next = wrow_reg + ROW_ONE;
            if (d_cnt != wrow_reg) begin
                err_next = 1'b1;
            end
            if (wrow_reg == '0) begin
                for (int b = 0; b < NBUF; b++) begin
                    if (wptr_reg == PW'(b)) begin
                        mode_next[b] = d_mode;
                    end
                end
            end
            if (wr_done) begin
                wptr_next = (wptr_reg == BUF_LAST) ? '0 : wptr_reg + BUF_ONE;
            end
        end

        if (rd_fire) begin
            q_next       = rd_row;
            q_cnt_next   = rcol_reg;
            q_mode_next  = rd_mode;
            q_last_next  = (rcol_reg == ROW_LAST);
            q_valid_next = 1'b1;
            rcol_next    = rcol_reg + ROW_ONE;
            if (rd_done) begin
                rptr_next = (rptr_reg == BUF_LAST) ? '0 : rptr_reg + BUF_ONE;
            end
        end else if (advance) begin
            q_valid_next = 1'b0;
        end

        case ({wr_done, rd_done})
            2'b10:   occ_next = occ_reg + OCC_ONE;
            2'b01:   occ_next = occ_reg - OCC_ONE;
            default: occ_next = occ_reg;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_reg    <= '0;
            rptr_reg    <= '0;
            wrow_reg    <= '0;
            rcol_reg    <= '0;
            occ_reg     <= '0;
            mode_reg    <= '0;
            err_reg     <= 1'b0;
            q_reg       <= '0;
            q_cnt_reg   <= '0;
            q_mode_reg  <= 1'b0;
            q_last_reg  <= 1'b0;
            q_valid_reg <= 1'b0;
        end else begin
            wptr_reg    <= wptr_next;
            rptr_reg    <= rptr_next;
            wrow_reg    <= wrow_next;
            rcol_reg    <= rcol_next;
            occ_reg     <= occ_next;
            mode_reg    <= mode_next;
            err_reg     <= err_next;
            q_reg       <= q_next;
            q_cnt_reg   <= q_cnt_next;
            q_mode_reg  <= q_mode_next;
            q_last_reg  <= q_last_next;
            q_valid_reg <= q_valid_next;
        end
    end

    assign q       = q_reg;
    assign q_cnt   = q_cnt_reg;
    assign q_mode  = q_mode_reg;
    assign q_last  = q_last_reg;
    assign q_valid = q_valid_reg;
    assign err_seq = err_reg;

endmodule

// File: tb/tb_transpose_nxn.sv
// Directed bench for transpose_nxn (N=8, QW=12, NBUF=2); element (r,c) of a block = base + 16r + c.
`timescale 1ns/1ps
module tb_transpose_nxn;
    import jenc_pkg::*;

    localparam int N    = 8;
    localparam int QW   = 12;
    localparam int NBUF = 2;
    localparam int CW   = 3;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [N-1:0][QW-1:0]  d;
    logic [CW-1:0]         d_cnt;
    logic                  d_mode;
    logic                  d_valid;
    logic                  d_hold;
    logic [N-1:0][QW-1:0]  q;
    logic [CW-1:0]         q_cnt;
    logic                  q_mode;
    logic                  q_last;
    logic                  q_valid;
    logic                  q_hold;
    logic                  err_seq;

    transpose_nxn #(.N(N), .QW(QW), .NBUF(NBUF)) dut (
        .clk     (clk),
        .reset   (reset),
        .d       (d),
        .d_cnt   (d_cnt),
        .d_mode  (d_mode),
        .d_valid (d_valid),
        .d_hold  (d_hold),
        .q       (q),
        .q_cnt   (q_cnt),
        .q_mode  (q_mode),
        .q_last  (q_last),
        .q_valid (q_valid),
        .q_hold  (q_hold),
        .err_seq (err_seq)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Expected blocks in emission order, and the column expected next.
    int   exp_base[$];
    logic exp_mode[$];
    int   out_col = 0;

    logic [N-1:0][QW-1:0] last_q;
    logic [CW-1:0]        last_cnt;
    int   beats = 0;
    int   mode1_beats = 0;
    int   gaps = 0;
    int   gap_from = 0;
    int   gap_to = 0;
    logic hold_seen = 1'b0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode=0: column c of the block; mode=1: row c of the block.
    function automatic logic [N-1:0][QW-1:0] beat_vec(input int base, input logic mode, input int c);
        logic [N-1:0][QW-1:0] v;
        elem_t e;
        for (int i = 0; i < N; i++) begin
            e = elem_t'(mode ? (base + 16 * c + i) : (base + 16 * i + c));
            v[i] = e;
        end
        return v;
    endfunction

    // One clock; outputs are inspected 1ns after the edge.
    task automatic tick();
        logic take;
        logic pv;
        take = q_valid & ~q_hold;
        pv   = q_valid;
        if (d_valid && d_hold) hold_seen = 1'b1;
        @(posedge clk);
        #1;
        if (q_valid && (take || !pv)) begin
            beats++;
            check("beat_expected", exp_base.size() != 0, 1'b1);
            if (exp_base.size() != 0) begin
                check("q_cnt", q_cnt, out_col);
                check("q_last", q_last, out_col == N - 1);
                check("q_mode", q_mode, exp_mode[0]);
                check("q_data", q, beat_vec(exp_base[0], exp_mode[0], out_col));
                $display("[TB] beat col=%0d mode=%0d last=%0d q=%h", q_cnt, q_mode, q_last, q);
                if (q_mode) mode1_beats++;
                out_col++;
                if (out_col == N) begin
                    out_col = 0;
                    void'(exp_base.pop_front());
                    void'(exp_mode.pop_front());
                end
            end
        end else if (q_valid && pv && !take) begin
            check("held_q", q, last_q);
            check("held_cnt", q_cnt, last_cnt);
        end
        if (beats > gap_from && beats < gap_to && !q_valid) gaps++;
        last_q   = q;
        last_cnt = q_cnt;
    endtask

    task automatic send_row(input int base, input logic mode, input int r, input int cnt);
        int guard;
        guard   = 0;
        d       = beat_vec(base, 1'b1, r);
        d_cnt   = CW'(cnt);
        d_mode  = mode;
        d_valid = 1'b1;
        while (d_hold && guard < 200) begin
            tick();
            guard++;
        end
        check("accept_timeout", d_hold, 1'b0);
        tick();
        d_valid = 1'b0;
    endtask

    // d_mode is inverted on rows 1..N-1 so only row 0 may decide the block mode.
    task automatic send_block(input int base, input logic mode, input int bad_row);
        for (int r = 0; r < N; r++) begin
            send_row(base, (r == 0) ? mode : ~mode, r, (r == bad_row) ? 3 : r);
        end
        exp_base.push_back(base);
        exp_mode.push_back(mode);
    endtask

    task automatic drain(input int n);
        d_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        check("rst_q_valid", q_valid, 1'b0);
        check("rst_err_seq", err_seq, 1'b0);
        check("rst_d_hold", d_hold, 1'b0);
        check("rst_q", q, '0);
        exp_base.delete();
        exp_mode.delete();
        out_col = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int b0;
        reset   = 1'b1;
        d       = '0;
        d_cnt   = '0;
        d_mode  = 1'b0;
        d_valid = 1'b0;
        q_hold  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_d_hold", d_hold, 1'b0);
        check("reset_q", q, '0);
        check("reset_q_cnt", q_cnt, '0);
        check("reset_q_mode", q_mode, 1'b0);
        check("reset_q_last", q_last, 1'b0);
        check("reset_q_valid", q_valid, 1'b0);
        check("reset_err_seq", err_seq, 1'b0);
        reset = 1'b0;
        tick();

        // 1: single block, latency and column order
        send_block(0, 1'b0, -1);
        check("lat_edge_k", q_valid, 1'b0);
        tick();
        check("lat_edge_k1", q_valid, 1'b1);
        check("lat_first_cnt", q_cnt, '0);
        drain(10);
        check("t1_beats", beats, 8);
        check("t1_drained", exp_base.size(), 0);

        // 2: three back-to-back blocks at full rate
        b0 = beats;
        gap_from = b0;
        gap_to = b0 + 24;
        hold_seen = 1'b0;
        send_block(256, 1'b0, -1);
        send_block(512, 1'b0, -1);
        send_block(-1024, 1'b0, -1);
        drain(12);
        check("t2_beats", beats - b0, 24);
        check("t2_no_d_hold", hold_seen, 1'b0);
        check("t2_no_gaps", gaps, 0);
        gap_to = 0;

        // 3: consumer stalled, storage fills, then released
        q_hold = 1'b1;
        send_block(100, 1'b0, -1);
        send_block(-300, 1'b0, -1);
        check("t3_full_hold", d_hold, 1'b1);
        d       = beat_vec(700, 1'b1, 0);
        d_cnt   = '0;
        d_mode  = 1'b0;
        d_valid = 1'b1;
        repeat (3) tick();
        check("t3_still_hold", d_hold, 1'b1);
        check("t3_first_held", q_cnt, '0);
        q_hold = 1'b0;
        send_block(700, 1'b0, -1);
        drain(30);
        check("t3_drained", exp_base.size(), 0);

        // 4: passthrough block between two transpose blocks
        mode1_beats = 0;
        send_block(0, 1'b0, -1);
        send_block(1000, 1'b1, -1);
        send_block(-2000, 1'b0, -1);
        drain(30);
        check("t4_mode1_beats", mode1_beats, 8);
        check("t4_drained", exp_base.size(), 0);

        // 5: sequence error is sticky, data kept in arrival order, cleared by reset
        send_block(32, 1'b0, 1);
        tick();
        check("t5_err_set", err_seq, 1'b1);
        drain(12);
        check("t5_err_sticky", err_seq, 1'b1);
        send_block(64, 1'b0, -1);
        tick();
        tick();
        check("t5_valid_before_rst", q_valid, 1'b1);
        pulse_reset();

        // 6: reset after a partial block leaves no stale rows
        for (int r = 0; r < 5; r++) begin
            send_row(-500, 1'b0, r, r);
        end
        pulse_reset();
        b0 = beats;
        send_block(48, 1'b0, -1);
        drain(12);
        check("t6_beats", beats - b0, 8);
        check("t6_drained", exp_base.size(), 0);
        check("t6_err_clear", err_seq, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
